// File: rtl/vx_mem_req_throttle_pkg.sv
// Shared types for the memory request throttle: request buffer depth and occupancy type.
package vx_mem_req_throttle_pkg;

  localparam int REQ_BUF_SIZE = 2;

  typedef logic [$clog2(REQ_BUF_SIZE+1)-1:0] buf_cnt_t;

endpackage

// File: rtl/vx_mem_req_throttle_buf.sv
// Two-entry elastic buffer with a registered output stage and a skid entry.
// Ready is registered: it only depends on whether the skid entry is occupied.
module vx_mem_req_throttle_buf
  import vx_mem_req_throttle_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output buf_cnt_t          count
);

  logic              vld_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] data_p1;
  logic              push;
  logic              pop;

  assign in_ready  = ~vld_p0;
  assign push      = in_valid & ~vld_p0;
  assign pop       = vld_p1 & out_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign count     = buf_cnt_t'({1'b0, vld_p0}) + buf_cnt_t'({1'b0, vld_p1});

  // p0 = skid entry (only occupied while p1 is stalled), p1 = output register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (vld_p0) begin
      if (pop) vld_p0 <= 1'b0;
    end else if (push) begin
      if (vld_p1 & ~pop) vld_p0 <= 1'b1;
      else               vld_p1 <= 1'b1;
    end else if (pop) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      if (pop) data_p1 <= data_p0;
    end else if (push) begin
      if (vld_p1 & ~pop) data_p0 <= in_data;
      else               data_p1 <= in_data;
    end
  end

endmodule

// File: rtl/vx_mem_req_throttle.sv
// Memory-side flow regulator: buffers requests, caps outstanding reads with credits,
// passes responses straight through and offers a drain/drained quiesce handshake.
module vx_mem_req_throttle
  import vx_mem_req_throttle_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,

  input  logic                                 in_req_valid,
  input  logic                                 in_req_rw,
  input  logic [DATA_WIDTH/8-1:0]              in_req_byteen,
  input  logic [ADDR_WIDTH-1:0]                in_req_addr,
  input  logic [DATA_WIDTH-1:0]                in_req_data,
  input  logic [TAG_WIDTH-1:0]                 in_req_tag,
  output logic                                 in_req_ready,

  output logic                                 out_req_valid,
  output logic                                 out_req_rw,
  output logic [DATA_WIDTH/8-1:0]              out_req_byteen,
  output logic [ADDR_WIDTH-1:0]                out_req_addr,
  output logic [DATA_WIDTH-1:0]                out_req_data,
  output logic [TAG_WIDTH-1:0]                 out_req_tag,
  input  logic                                 out_req_ready,

  input  logic                                 out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                out_rsp_data,
  input  logic [TAG_WIDTH-1:0]                 out_rsp_tag,
  output logic                                 out_rsp_ready,

  output logic                                 in_rsp_valid,
  output logic [DATA_WIDTH-1:0]                in_rsp_data,
  output logic [TAG_WIDTH-1:0]                 in_rsp_tag,
  input  logic                                 in_rsp_ready,

  input  logic                                 drain,
  output logic                                 drained,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending,
  output logic                                 busy,
  output logic                                 underflow
);

  localparam int CW = $clog2(MAX_PENDING+1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

  typedef struct packed {
    logic                    rw;
    logic [DATA_WIDTH/8-1:0] byteen;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [TAG_WIDTH-1:0]    tag;
  } mem_req_t;

  // A response without a matching credit leaves the count at zero.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic          take,
                                                input logic          give);
    case ({take, give})
      2'b10:   return cur + CW'(1);
      2'b01:   return (cur == '0) ? cur : cur - CW'(1);
      default: return cur;
    endcase
  endfunction

  mem_req_t req_in;
  mem_req_t req_out;
  buf_cnt_t buf_cnt;
  logic     buf_ready;
  logic     buf_empty;
  logic     admit_ok;
  logic     read_admit;
  logic     rsp_fire;

  assign req_in = '{rw: in_req_rw, byteen: in_req_byteen, addr: in_req_addr,
                    data: in_req_data, tag: in_req_tag};

  // Credit check uses the registered count, so a same-cycle response never frees a slot.
  assign admit_ok     = ~drain & (in_req_rw | (pending != PEND_MAX));
  assign in_req_ready = buf_ready & admit_ok;
  assign read_admit   = in_req_valid & in_req_ready & ~in_req_rw;

  vx_mem_req_throttle_buf #(
    .DATA_W ($bits(mem_req_t))
  ) req_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_req_valid & admit_ok),
    .in_ready  (buf_ready),
    .in_data   (req_in),
    .out_valid (out_req_valid),
    .out_ready (out_req_ready),
    .out_data  (req_out),
    .count     (buf_cnt)
  );

  assign out_req_rw     = req_out.rw;
  assign out_req_byteen = req_out.byteen;
  assign out_req_addr   = req_out.addr;
  assign out_req_data   = req_out.data;
  assign out_req_tag    = req_out.tag;

  assign in_rsp_valid  = out_rsp_valid;
  assign in_rsp_data   = out_rsp_data;
  assign in_rsp_tag    = out_rsp_tag;
  assign out_rsp_ready = in_rsp_ready;
  assign rsp_fire      = out_rsp_valid & in_rsp_ready;

  assign buf_empty = (buf_cnt == '0);
  assign busy      = ~buf_empty | (pending != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      underflow <= 1'b0;
      drained   <= 1'b0;
    end else begin
      pending <= credit_next(pending, read_admit, rsp_fire);
      if (rsp_fire && pending == '0) underflow <= 1'b1;
      drained <= drain & buf_empty & (pending == '0);
    end
  end

endmodule

// File: tb/tb_vx_mem_req_throttle.sv
// Directed and randomized bench for vx_mem_req_throttle against a queue-based reference model.
module tb_vx_mem_req_throttle;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int MP = 4;
  localparam int CW = $clog2(MP+1);

  typedef struct packed {
    logic          rw;
    logic [DW/8-1:0] byteen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic in_req_valid, in_req_rw, in_req_ready;
  logic [DW/8-1:0] in_req_byteen;
  logic [AW-1:0] in_req_addr;
  logic [DW-1:0] in_req_data;
  logic [TW-1:0] in_req_tag;
  logic out_req_valid, out_req_rw, out_req_ready;
  logic [DW/8-1:0] out_req_byteen;
  logic [AW-1:0] out_req_addr;
  logic [DW-1:0] out_req_data;
  logic [TW-1:0] out_req_tag;
  logic out_rsp_valid, out_rsp_ready;
  logic [DW-1:0] out_rsp_data;
  logic [TW-1:0] out_rsp_tag;
  logic in_rsp_valid, in_rsp_ready;
  logic [DW-1:0] in_rsp_data;
  logic [TW-1:0] in_rsp_tag;
  logic drain, drained, busy, underflow;
  logic [CW-1:0] pending;

  vx_mem_req_throttle #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_byteen(out_req_byteen),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .drain(drain), .drained(drained), .pending(pending), .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: requests admitted but not yet accepted by memory, and credit count.
  req_t q[$];
  int   m_pend;
  bit   m_drained;
  bit   m_under;
  bit   m_ready;
  int   tests;
  int   fails;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit v, input bit rw, input logic [TW-1:0] tag);
    in_req_valid  = v;
    in_req_rw     = rw;
    in_req_tag    = tag;
    in_req_addr   = AW'($urandom);
    in_req_data   = DW'($urandom);
    in_req_byteen = (DW/8)'($urandom);
  endtask

  task automatic set_rsp(input bit v);
    out_rsp_valid = v;
    out_rsp_data  = DW'($urandom);
    out_rsp_tag   = TW'($urandom);
  endtask

  task automatic sample();
    @(negedge clk);
    m_ready = (q.size() < 2) && !drain && (in_req_rw || m_pend != MP);
    check("in_req_ready", 128'(in_req_ready), 128'(m_ready));
    check("out_req_valid", 128'(out_req_valid), 128'(q.size() != 0));
    if (q.size() != 0)
      check("out_req_payload",
            128'({out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag}),
            128'(q[0]));
    check("pending", 128'(pending), 128'(m_pend));
    check("busy", 128'(busy), 128'(q.size() != 0 || m_pend != 0));
    check("drained", 128'(drained), 128'(m_drained));
    check("underflow", 128'(underflow), 128'(m_under));
    check("rsp_pass", 128'({in_rsp_valid, in_rsp_data, in_rsp_tag, out_rsp_ready}),
          128'({out_rsp_valid, out_rsp_data, out_rsp_tag, in_rsp_ready}));
  endtask

  task automatic advance();
    bit   adm;
    bit   fire;
    bit   dr;
    int   n;
    req_t r;
    adm  = in_req_valid && m_ready;
    fire = out_rsp_valid && in_rsp_ready;
    dr   = drain && q.size() == 0 && m_pend == 0;
    if (out_req_ready && q.size() != 0) void'(q.pop_front());
    if (adm) begin
      r.rw = in_req_rw; r.byteen = in_req_byteen; r.addr = in_req_addr;
      r.data = in_req_data; r.tag = in_req_tag;
      q.push_back(r);
    end
    if (fire && m_pend == 0) m_under = 1'b1;
    n = m_pend + ((adm && !in_req_rw) ? 1 : 0) - (fire ? 1 : 0);
    m_pend = (n < 0) ? 0 : n;
    m_drained = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_req_valid = 1'b0;
    out_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_pend = 0;
    m_drained = 1'b0;
    m_under = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drain = 1'b0;
    out_req_ready = 1'b1;
    in_rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, '0);
    set_rsp(1'b0);
    do_reset();

    // Reset values
    sample();
    check("rst_ready", 128'(in_req_ready), 128'(1));
    check("rst_out_valid", 128'(out_req_valid), 128'(0));
    check("rst_pending", 128'(pending), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    advance();

    // Read throughput and credit cap
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 1'b0, TW'(16 + i));
      sample();
      check("thr_ready", 128'(in_req_ready), 128'(i < 4));
      advance();
    end
    set_rsp(1'b1);
    sample();
    check("thr_rsp_ready", 128'(in_req_ready), 128'(0));
    check("thr_pend4", 128'(pending), 128'(4));
    advance();
    set_rsp(1'b0);
    sample();
    check("thr_after_ready", 128'(in_req_ready), 128'(1));
    check("thr_pend3", 128'(pending), 128'(3));
    advance();
    in_req_valid = 1'b0;

    // Writes bypass credits
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, TW'(32 + i));
      sample();
      check("wr_ready", 128'(in_req_ready), 128'(1));
      advance();
    end
    in_req_valid = 1'b0;
    sample();
    check("wr_pend", 128'(pending), 128'(4));
    advance();
    set_rsp(1'b1);
    repeat (4) tick();
    set_rsp(1'b0);

    // Backpressure
    out_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, TW'(48 + i));
      sample();
      check("bp_ready", 128'(in_req_ready), 128'(i < 2));
      advance();
    end
    in_req_valid = 1'b0;
    out_req_ready = 1'b1;
    sample();
    check("bp_tag0", 128'(out_req_tag), 128'(48));
    advance();
    sample();
    check("bp_tag1", 128'(out_req_tag), 128'(49));
    advance();
    sample();
    check("bp_empty", 128'(out_req_valid), 128'(0));
    advance();

    // Simultaneous admission and response
    set_req(1'b1, 1'b0, TW'(64));
    set_rsp(1'b1);
    sample();
    check("sim_ready", 128'(in_req_ready), 128'(1));
    advance();
    set_rsp(1'b0);
    in_req_valid = 1'b0;
    sample();
    check("sim_pend2", 128'(pending), 128'(2));
    advance();
    set_req(1'b1, 1'b0, TW'(65)); tick();
    set_req(1'b1, 1'b0, TW'(66)); tick();
    set_req(1'b1, 1'b0, TW'(67));
    set_rsp(1'b1);
    sample();
    check("sim_full_ready", 128'(in_req_ready), 128'(0));
    check("sim_pend4", 128'(pending), 128'(4));
    advance();
    set_rsp(1'b0);
    sample();
    check("sim_after_ready", 128'(in_req_ready), 128'(1));
    check("sim_pend3", 128'(pending), 128'(3));
    advance();
    in_req_valid = 1'b0;
    set_rsp(1'b1);
    repeat (4) tick();
    set_rsp(1'b0);

    // Drain with one buffered read and three outstanding
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, TW'(80 + i));
      tick();
    end
    in_req_valid = 1'b0;
    tick();
    out_req_ready = 1'b0;
    set_req(1'b1, 1'b0, TW'(83));
    tick();
    drain = 1'b1;
    set_req(1'b1, 1'b0, TW'(84));
    sample();
    check("dr_ready", 128'(in_req_ready), 128'(0));
    check("dr_buffered", 128'(out_req_valid), 128'(1));
    check("dr_pend4", 128'(pending), 128'(4));
    advance();
    out_req_ready = 1'b1;
    tick();
    set_rsp(1'b1);
    repeat (4) tick();
    set_rsp(1'b0);
    sample();
    check("dr_pend0", 128'(pending), 128'(0));
    check("dr_lag", 128'(drained), 128'(0));
    advance();
    sample();
    check("dr_drained", 128'(drained), 128'(1));
    advance();
    drain = 1'b0;
    sample();
    check("dr_release", 128'(in_req_ready), 128'(1));
    advance();
    in_req_valid = 1'b0;
    set_rsp(1'b1);
    tick();
    set_rsp(1'b0);

    // Underflow, then reset with buffered requests
    set_rsp(1'b1);
    tick();
    set_rsp(1'b0);
    sample();
    check("uf_flag", 128'(underflow), 128'(1));
    check("uf_pend", 128'(pending), 128'(0));
    advance();
    out_req_ready = 1'b0;
    set_req(1'b1, 1'b1, TW'(96)); tick();
    set_req(1'b1, 1'b1, TW'(97)); tick();
    in_req_valid = 1'b0;
    sample();
    check("pre_rst_busy", 128'(busy), 128'(1));
    advance();
    do_reset();
    sample();
    check("rst2_out_valid", 128'(out_req_valid), 128'(0));
    check("rst2_busy", 128'(busy), 128'(0));
    check("rst2_underflow", 128'(underflow), 128'(0));
    check("rst2_ready", 128'(in_req_ready), 128'(1));
    advance();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_req($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, TW'($urandom));
      out_req_ready = ($urandom_range(0, 9) < 7);
      in_rsp_ready  = ($urandom_range(0, 9) < 8);
      set_rsp(m_pend > 0 && $urandom_range(0, 9) < 4);
      if ($urandom_range(0, 49) == 0) drain = ~drain;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
